cpu_stack_unit: RTL and testbench
=================================

// Module: cpu_stack_unit
// PURPOSE
//  Parametrised data + return stack engine for the next-generation eCPU core.
//  - TOS/NOS are held in registers; deeper data entries and all return entries are in synchronous RAM.
//  - Executes one data-stack op and one return-stack op per clock.
//  - Adds configurable width/depth and overflow/underflow guarding, which the current core lacks.
// PARAMETERS
//  DW      32   data/return word width
//  DDEPTH  256  data stack RAM slots (power of 2); max data depth = DDEPTH-1
//  RDEPTH  256  return stack RAM slots (power of 2); max return depth = RDEPTH-1
// PORTS
//  clk      in   1                  system clock
//  rst      in   1                  reset, asynchronous, active-high
//  run      in   1                  0 = synchronous clear of stacks (same state as reset)
//  d_op     in   4                  data op (encodings in cpu_stack_pkg)
//  d_in     in   DW                 operand for PUSH/REPL/BINOP
//  tos      out  DW                 top of data stack (registered)
//  nos      out  DW                 next on data stack (registered)
//  sp       out  clog2(DDEPTH)      data depth
//  r_op     in   2                  0 NONE, 1 RPUSH(r_in), 2 RPOP, 3 NONE
//  r_in     in   DW                 return push value
//  r_top    out  DW                 top of return stack (registered)
//  rp       out  clog2(RDEPTH)      return depth
//  ovf      out  1                  sticky overflow (data|return)
//  unf      out  1                  sticky underflow (data|return)
//  err_clr  in   1                  clears ovf/unf
// BEHAVIOUR
//  - Reset or run=0: tos, nos, r_top, sp, rp, ovf and unf all become 0. RAM contents are not cleared.
//  - Ops are sampled at the posedge; results are visible on tos/nos/r_top one cycle later.
//    Back-to-back ops every cycle with no stall.
//  - Data ops (0-8), with required min depth in []:
//    NOP[0]; PUSH[0]; DROP[1]; DUP[1]; SWAP[2]; OVER[2]; ROT[3] (a b c -- b c a); REPL[1] (tos<=d_in);
//    BINOP[2] (tos<=d_in, nos<=RAM, sp-1). Codes 9-15 are treated as NOP.
//  - RAM[sp] always holds the entry below NOS.
//    - Push-type ops (PUSH/DUP/OVER): write nos to RAM[sp+1], sp+1.
//    - Pop-type ops (DROP/BINOP): nos<=RAM[sp], sp-1.
//    - ROT: tos<=RAM[sp], nos<=old tos, RAM[sp]<=old nos.
//  - RAM read address = next sp, registered. Read-during-write to the same address returns the
//    new data (write-first bypass, implemented inside the RAM wrapper).
//  - Return stack: r_top is a register.
//    - RPUSH writes r_top to RAM[rp+1] and sets r_top<=r_in.
//    - RPOP sets r_top<=RAM[rp] and decrements rp.
//  - Data and return ops in the same cycle are independent. to_r is expressed as DROP + RPUSH(r_in=tos).
//  - err_clr has priority over a same-cycle error set; the flag clears.
// CONFIGURATION
//  CPU_STACK_GUARD_EN defined:
//    - Push when depth==max, or any op below its min depth, is suppressed entirely:
//      tos/nos/r_top/sp/rp are unchanged and no RAM write occurs.
//    - ovf or unf is set on the next cycle.
//  CPU_STACK_GUARD_EN undefined:
//    - No checks are performed; sp/rp wrap modulo depth.
//    - ovf/unf are tied to 0.
// STRUCTURE
//  cpu_stack_pkg: d_op/r_op encodings, min-depth table function, DW/DEPTH-derived width helpers.
//  Sub-module stk_ram_1r1w (DW, DEPTH): sync 1R1W RAM with write-first bypass. Instantiated twice.
// TESTING
//  1. Reset, then PUSH 5,6,7 -> tos=7 nos=6 sp=3; DROP x2 -> tos=5 sp=1.
//  2. PUSH 1,2,3; ROT -> tos=1 nos=3, then DROP -> tos=3 nos=2.
//  3. PUSH 10,20; BINOP d_in=30 -> tos=30 sp=1; SWAP at depth 1 -> unf=1 with tos unchanged (guard on).
//  4. Push DDEPTH-1 values i, then one more -> ovf=1 sp=DDEPTH-1 tos=DDEPTH-2.
//     Guard off: same stimulus gives sp wraps to 0 and ovf=0.
//  5. Same cycle: DROP + RPUSH r_in=tos(0xAB) -> r_top=0xAB rp=1; RPOP -> r_top=prior, rp=0.
//  6. Assert rst mid-burst of alternating PUSH/DROP -> all outputs 0 asynchronously; first op after release behaves as from empty.

Source files
------------

// File: rtl/cpu_stack_pkg.sv
// cpu_stack_pkg: opcode encodings, per-op minimum depth table and pointer
// width helper shared by the stack engine and its users.
package cpu_stack_pkg;

   // Data-stack operations; codes 9-15 decode as NOP.
   typedef enum logic [3:0] {
      D_NOP   = 4'd0,
      D_PUSH  = 4'd1,
      D_DROP  = 4'd2,
      D_DUP   = 4'd3,
      D_SWAP  = 4'd4,
      D_OVER  = 4'd5,
      D_ROT   = 4'd6,
      D_REPL  = 4'd7,
      D_BINOP = 4'd8
   } d_op_e;

   // Return-stack operations; code 3 is a second NOP.
   typedef enum logic [1:0] {
      R_NONE  = 2'd0,
      R_PUSH  = 2'd1,
      R_POP   = 2'd2,
      R_NONE3 = 2'd3
   } r_op_e;

   // Number of entries an op must find on the data stack to be legal.
   function automatic logic [1:0] d_min_depth(input logic [3:0] op);
      case (op)
         D_DROP, D_DUP, D_REPL:    return 2'd1;
         D_SWAP, D_OVER, D_BINOP:  return 2'd2;
         D_ROT:                    return 2'd3;
         default:                  return 2'd0;
      endcase
   endfunction

   // Ops that grow the data stack by one entry.
   function automatic logic d_is_push(input logic [3:0] op);
      return (op == D_PUSH) || (op == D_DUP) || (op == D_OVER);
   endfunction

   // Depth/pointer width for a power-of-two slot count.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/cpu_stack_unit_if.sv
// cpu_stack_unit_if: op/operand inputs and stack-state outputs of the
// stack engine. master = core issuing ops, slave = stack unit.
interface cpu_stack_unit_if #(
   parameter int DW  = 32,
   parameter int SPW = 8,
   parameter int RPW = 8
);
   logic           run;
   logic [3:0]     d_op;
   logic [DW-1:0]  d_in;
   logic [DW-1:0]  tos;
   logic [DW-1:0]  nos;
   logic [SPW-1:0] sp;
   logic [1:0]     r_op;
   logic [DW-1:0]  r_in;
   logic [DW-1:0]  r_top;
   logic [RPW-1:0] rp;
   logic           ovf;
   logic           unf;
   logic           err_clr;

   modport master (
      output run, d_op, d_in, r_op, r_in, err_clr,
      input  tos, nos, sp, r_top, rp, ovf, unf
   );

   modport slave (
      input  run, d_op, d_in, r_op, r_in, err_clr,
      output tos, nos, sp, r_top, rp, ovf, unf
   );
endinterface

// File: rtl/stk_ram_1r1w.sv
// stk_ram_1r1w: synchronous 1-read/1-write RAM, registered read, write-first
// bypass when reading the address being written in the same cycle.
module stk_ram_1r1w #(
   parameter int DW    = 32,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DW-1:0]            wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DW-1:0]            rdata_o
);
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;

   // Write port plus registered read that forwards same-address write data.
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (we_i && (waddr_i == raddr_i)) rdata_q <= wdata_i;
      else                              rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/cpu_stack_unit.sv
// cpu_stack_unit: data + return stack engine. TOS/NOS/r_top live in
// registers, deeper entries in two stk_ram_1r1w instances. Each RAM is read
// at the next-cycle pointer, so its output always holds RAM[ptr] (the entry
// just below NOS, or just below r_top).
// Optional feature: define CPU_STACK_GUARD_EN to suppress overflowing /
// underflowing ops and raise sticky ovf/unf; otherwise pointers wrap freely.
module cpu_stack_unit
   import cpu_stack_pkg::*;
#(
   parameter int DW     = 32,
   parameter int DDEPTH = 256,
   parameter int RDEPTH = 256
) (
   input  logic            clk,
   input  logic            rst,
   cpu_stack_unit_if.slave bus
);
   localparam int SPW = ptr_w(DDEPTH);
   localparam int RPW = ptr_w(RDEPTH);
`ifdef CPU_STACK_GUARD_EN
   localparam logic [SPW-1:0] SP_MAX = SPW'(DDEPTH - 1);
   localparam logic [RPW-1:0] RP_MAX = RPW'(RDEPTH - 1);
`endif

   logic [DW-1:0]  tos_q, tos_d, nos_q, nos_d, rtop_q, rtop_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic [RPW-1:0] rp_q, rp_d;
   logic           ovf_q, unf_q;

   logic           d_we, r_we;
   logic [SPW-1:0] d_wa;
   logic [RPW-1:0] r_wa;
   logic [DW-1:0]  d_wd, d_rd, r_wd, r_rd;
   logic           d_ovf, d_unf, r_ovf, r_unf;

   // Data stack next state, RAM write and guard decision.
   always_comb begin
      tos_d = tos_q;
      nos_d = nos_q;
      sp_d  = sp_q;
      d_we  = 1'b0;
      d_wa  = sp_q + SPW'(1);
      d_wd  = nos_q;
      d_ovf = 1'b0;
      d_unf = 1'b0;
`ifdef CPU_STACK_GUARD_EN
      if (sp_q < SPW'(d_min_depth(bus.d_op)))           d_unf = 1'b1;
      else if (d_is_push(bus.d_op) && (sp_q == SP_MAX)) d_ovf = 1'b1;
`endif
      if (!bus.run) begin
         tos_d = '0;
         nos_d = '0;
         sp_d  = '0;
      end else if (!d_ovf && !d_unf) begin
         case (bus.d_op)
            D_PUSH:  begin d_we = 1'b1; nos_d = tos_q; tos_d = bus.d_in; sp_d = sp_q + SPW'(1); end
            D_DROP:  begin tos_d = nos_q; nos_d = d_rd; sp_d = sp_q - SPW'(1); end
            D_DUP:   begin d_we = 1'b1; nos_d = tos_q; sp_d = sp_q + SPW'(1); end
            D_SWAP:  begin tos_d = nos_q; nos_d = tos_q; end
            D_OVER:  begin d_we = 1'b1; nos_d = tos_q; tos_d = nos_q; sp_d = sp_q + SPW'(1); end
            // Third entry rises to TOS; old NOS sinks into its RAM slot.
            D_ROT:   begin d_we = 1'b1; d_wa = sp_q; tos_d = d_rd; nos_d = tos_q; end
            D_REPL:  tos_d = bus.d_in;
            D_BINOP: begin tos_d = bus.d_in; nos_d = d_rd; sp_d = sp_q - SPW'(1); end
            default: ;
         endcase
      end
   end

   // Return stack next state, RAM write and guard decision.
   always_comb begin
      rtop_d = rtop_q;
      rp_d   = rp_q;
      r_we   = 1'b0;
      r_wa   = rp_q + RPW'(1);
      r_wd   = rtop_q;
      r_ovf  = 1'b0;
      r_unf  = 1'b0;
`ifdef CPU_STACK_GUARD_EN
      if ((bus.r_op == R_PUSH) && (rp_q == RP_MAX))   r_ovf = 1'b1;
      else if ((bus.r_op == R_POP) && (rp_q == '0))   r_unf = 1'b1;
`endif
      if (!bus.run) begin
         rtop_d = '0;
         rp_d   = '0;
      end else if (!r_ovf && !r_unf) begin
         case (bus.r_op)
            R_PUSH:  begin r_we = 1'b1; rtop_d = bus.r_in; rp_d = rp_q + RPW'(1); end
            R_POP:   begin rtop_d = r_rd; rp_d = rp_q - RPW'(1); end
            default: ;
         endcase
      end
   end

   // State registers and sticky error flags; err_clr beats a same-cycle set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tos_q  <= '0;
         nos_q  <= '0;
         sp_q   <= '0;
         rtop_q <= '0;
         rp_q   <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         tos_q  <= tos_d;
         nos_q  <= nos_d;
         sp_q   <= sp_d;
         rtop_q <= rtop_d;
         rp_q   <= rp_d;
         if (!bus.run || bus.err_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            if (d_ovf || r_ovf) ovf_q <= 1'b1;
            if (d_unf || r_unf) unf_q <= 1'b1;
         end
      end
   end

   stk_ram_1r1w #(.DW(DW), .DEPTH(DDEPTH)) u_dram (
      .clk     (clk),
      .we_i    (d_we),
      .waddr_i (d_wa),
      .wdata_i (d_wd),
      .raddr_i (sp_d),
      .rdata_o (d_rd)
   );

   stk_ram_1r1w #(.DW(DW), .DEPTH(RDEPTH)) u_rram (
      .clk     (clk),
      .we_i    (r_we),
      .waddr_i (r_wa),
      .wdata_i (r_wd),
      .raddr_i (rp_d),
      .rdata_o (r_rd)
   );

   assign bus.tos   = tos_q;
   assign bus.nos   = nos_q;
   assign bus.sp    = sp_q;
   assign bus.r_top = rtop_q;
   assign bus.rp    = rp_q;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
endmodule

// File: tb/tb_cpu_stack_unit.sv
// tb_cpu_stack_unit: directed vector table plus hand sequences for the
// guard, wrap and asynchronous-reset corner cases of cpu_stack_unit.
module tb_cpu_stack_unit;
   import cpu_stack_pkg::*;

   localparam int DW = 16;
   localparam int DDEPTH = 16;
   localparam int RDEPTH = 8;
`ifdef CPU_STACK_GUARD_EN
   localparam bit G = 1'b1;
`else
   localparam bit G = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   cpu_stack_unit_if #(.DW(DW), .SPW(4), .RPW(3)) bus ();

   cpu_stack_unit #(.DW(DW), .DDEPTH(DDEPTH), .RDEPTH(RDEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        run;
      logic [3:0]  dop;
      logic [15:0] din;
      logic [1:0]  rop;
      logic [15:0] rin;
      logic [15:0] e_tos;
      logic [15:0] e_nos;
      logic [3:0]  e_sp;
      logic [15:0] e_rtop;
      logic [2:0]  e_rp;
   } vec_t;

   vec_t vecs[31];

   function automatic vec_t v(input logic run, input logic [3:0] dop, input logic [15:0] din,
                              input logic [1:0] rop, input logic [15:0] rin,
                              input logic [15:0] et, input logic [15:0] en, input logic [3:0] es,
                              input logic [15:0] er, input logic [2:0] ep);
      vec_t x;
      x.run = run; x.dop = dop; x.din = din; x.rop = rop; x.rin = rin;
      x.e_tos = et; x.e_nos = en; x.e_sp = es; x.e_rtop = er; x.e_rp = ep;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic run, input logic [3:0] dop, input logic [15:0] din,
                       input logic [1:0] rop, input logic [15:0] rin, input logic clr);
      @(negedge clk);
      bus.run = run; bus.d_op = dop; bus.d_in = din;
      bus.r_op = rop; bus.r_in = rin; bus.err_clr = clr;
      @(posedge clk);
      #1;
      $display("t=%0t run=%b dop=%0d din=%0h rop=%0d rin=%0h clr=%b -> tos=%0h nos=%0h sp=%0d rtop=%0h rp=%0d ovf=%b unf=%b",
               $time, run, dop, din, rop, rin, clr, bus.tos, bus.nos, bus.sp, bus.r_top, bus.rp, bus.ovf, bus.unf);
   endtask

   task automatic clear_stacks();
      step(1'b0, D_NOP, 16'h0, R_NONE, 16'h0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = v(1, D_PUSH,  16'h05, R_NONE, 0, 16'h05, 16'h00, 1, 16'h00, 0);
      vecs[1]  = v(1, D_PUSH,  16'h06, R_NONE, 0, 16'h06, 16'h05, 2, 16'h00, 0);
      vecs[2]  = v(1, D_PUSH,  16'h07, R_NONE, 0, 16'h07, 16'h06, 3, 16'h00, 0);
      vecs[3]  = v(1, D_DROP,  16'h00, R_NONE, 0, 16'h06, 16'h05, 2, 16'h00, 0);
      vecs[4]  = v(1, D_DROP,  16'h00, R_NONE, 0, 16'h05, 16'h00, 1, 16'h00, 0);
      vecs[5]  = v(0, D_PUSH,  16'h09, R_NONE, 0, 16'h00, 16'h00, 0, 16'h00, 0);
      vecs[6]  = v(1, D_PUSH,  16'h01, R_NONE, 0, 16'h01, 16'h00, 1, 16'h00, 0);
      vecs[7]  = v(1, D_PUSH,  16'h02, R_NONE, 0, 16'h02, 16'h01, 2, 16'h00, 0);
      vecs[8]  = v(1, D_PUSH,  16'h03, R_NONE, 0, 16'h03, 16'h02, 3, 16'h00, 0);
      vecs[9]  = v(1, D_ROT,   16'h00, R_NONE, 0, 16'h01, 16'h03, 3, 16'h00, 0);
      vecs[10] = v(1, D_DROP,  16'h00, R_NONE, 0, 16'h03, 16'h02, 2, 16'h00, 0);
      vecs[11] = v(0, D_NOP,   16'h00, R_NONE, 0, 16'h00, 16'h00, 0, 16'h00, 0);
      vecs[12] = v(1, D_PUSH,  16'h0A, R_NONE, 0, 16'h0A, 16'h00, 1, 16'h00, 0);
      vecs[13] = v(1, D_PUSH,  16'h14, R_NONE, 0, 16'h14, 16'h0A, 2, 16'h00, 0);
      vecs[14] = v(1, D_BINOP, 16'h1E, R_NONE, 0, 16'h1E, 16'h00, 1, 16'h00, 0);
      vecs[15] = v(0, D_NOP,   16'h00, R_NONE, 0, 16'h00, 16'h00, 0, 16'h00, 0);
      vecs[16] = v(1, D_PUSH,  16'hAB, R_NONE, 0, 16'hAB, 16'h00, 1, 16'h00, 0);
      vecs[17] = v(1, D_DROP,  16'h00, R_PUSH, 16'hAB, 16'h00, 16'h00, 0, 16'hAB, 1);
      vecs[18] = v(1, D_NOP,   16'h00, R_POP,  0, 16'h00, 16'h00, 0, 16'h00, 0);
      vecs[19] = v(1, D_NOP,   16'h00, R_PUSH, 16'h11, 16'h00, 16'h00, 0, 16'h11, 1);
      vecs[20] = v(1, D_NOP,   16'h00, R_PUSH, 16'h22, 16'h00, 16'h00, 0, 16'h22, 2);
      vecs[21] = v(1, D_NOP,   16'h00, R_POP,  0, 16'h00, 16'h00, 0, 16'h11, 1);
      vecs[22] = v(1, D_NOP,   16'h00, R_POP,  0, 16'h00, 16'h00, 0, 16'h00, 0);
      vecs[23] = v(1, D_PUSH,  16'h03, R_NONE, 0, 16'h03, 16'h00, 1, 16'h00, 0);
      vecs[24] = v(1, D_DUP,   16'h00, R_NONE, 0, 16'h03, 16'h03, 2, 16'h00, 0);
      vecs[25] = v(1, D_REPL,  16'h09, R_NONE, 0, 16'h09, 16'h03, 2, 16'h00, 0);
      vecs[26] = v(1, D_OVER,  16'h00, R_NONE, 0, 16'h03, 16'h09, 3, 16'h00, 0);
      vecs[27] = v(1, D_SWAP,  16'h00, R_NONE, 0, 16'h09, 16'h03, 3, 16'h00, 0);
      vecs[28] = v(1, D_DROP,  16'h00, R_NONE, 0, 16'h03, 16'h03, 2, 16'h00, 0);
      vecs[29] = v(1, D_DROP,  16'h00, R_NONE, 0, 16'h03, 16'h00, 1, 16'h00, 0);
      vecs[30] = v(1, 4'd12,   16'h77, R_NONE3, 16'h55, 16'h03, 16'h00, 1, 16'h00, 0);

      bus.run = 1'b1; bus.d_op = D_NOP; bus.d_in = '0;
      bus.r_op = R_NONE; bus.r_in = '0; bus.err_clr = 1'b0;

      // Reset state (asynchronous, before any clock edge)
      #1 rst = 1'b1;
      #1;
      chk("rst.tos", bus.tos, 0);   chk("rst.nos", bus.nos, 0);
      chk("rst.sp", bus.sp, 0);     chk("rst.rtop", bus.r_top, 0);
      chk("rst.rp", bus.rp, 0);     chk("rst.ovf", bus.ovf, 0);
      chk("rst.unf", bus.unf, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 31; i++) begin
         step(vecs[i].run, vecs[i].dop, vecs[i].din, vecs[i].rop, vecs[i].rin, 1'b0);
         chk($sformatf("v%0d.tos", i),  bus.tos,   vecs[i].e_tos);
         chk($sformatf("v%0d.nos", i),  bus.nos,   vecs[i].e_nos);
         chk($sformatf("v%0d.sp", i),   bus.sp,    vecs[i].e_sp);
         chk($sformatf("v%0d.rtop", i), bus.r_top, vecs[i].e_rtop);
         chk($sformatf("v%0d.rp", i),   bus.rp,    vecs[i].e_rp);
         chk($sformatf("v%0d.ovf", i),  bus.ovf,   0);
         chk($sformatf("v%0d.unf", i),  bus.unf,   0);
      end

      // SWAP at depth 1, then err_clr and its priority over a new error
      clear_stacks();
      step(1, D_PUSH, 16'h0A, R_NONE, 0, 0);
      step(1, D_PUSH, 16'h14, R_NONE, 0, 0);
      step(1, D_BINOP, 16'h1E, R_NONE, 0, 0);
      step(1, D_SWAP, 16'h00, R_NONE, 0, 0);
      chk("swap1.tos", bus.tos, G ? 32'h1E : 32'h00);
      chk("swap1.nos", bus.nos, G ? 32'h00 : 32'h1E);
      chk("swap1.sp", bus.sp, 1);
      chk("swap1.unf", bus.unf, G ? 1 : 0);
      step(1, D_NOP, 16'h00, R_NONE, 0, 1);
      chk("clr.unf", bus.unf, 0);
      step(1, D_SWAP, 16'h00, R_NONE, 0, 1);
      chk("clrprio.unf", bus.unf, 0);
      chk("clrprio.tos", bus.tos, 32'h1E);
      step(1, D_NOP, 16'h00, R_NONE, 0, 0);
      chk("clrhold.unf", bus.unf, 0);

      // Fill data stack to max depth, then one more push
      clear_stacks();
      for (int i = 0; i < DDEPTH - 1; i++) step(1, D_PUSH, 16'(i), R_NONE, 0, 0);
      chk("full.sp", bus.sp, DDEPTH - 1);
      chk("full.tos", bus.tos, DDEPTH - 2);
      chk("full.nos", bus.nos, DDEPTH - 3);
      step(1, D_PUSH, 16'h63, R_NONE, 0, 0);
      chk("dovf.sp", bus.sp, G ? DDEPTH - 1 : 0);
      chk("dovf.tos", bus.tos, G ? DDEPTH - 2 : 32'h63);
      chk("dovf.ovf", bus.ovf, G ? 1 : 0);
      step(1, D_DROP, 16'h00, R_NONE, 0, 0);
      chk("dovf_drop.tos", bus.tos, G ? DDEPTH - 3 : DDEPTH - 2);
      chk("dovf_drop.nos", bus.nos, G ? DDEPTH - 4 : DDEPTH - 3);
      chk("dovf_drop.sp", bus.sp, G ? DDEPTH - 2 : DDEPTH - 1);
      chk("dovf_drop.ovf", bus.ovf, G ? 1 : 0);

      // Return stack underflow from empty
      clear_stacks();
      chk("runclr.ovf", bus.ovf, 0);
      step(1, D_NOP, 16'h00, R_POP, 0, 0);
      chk("runf.rp", bus.rp, G ? 0 : RDEPTH - 1);
      chk("runf.unf", bus.unf, G ? 1 : 0);

      // Return stack overflow at max depth
      clear_stacks();
      for (int i = 1; i < RDEPTH; i++) step(1, D_NOP, 16'h00, R_PUSH, 16'(i), 0);
      chk("rfull.rp", bus.rp, RDEPTH - 1);
      step(1, D_NOP, 16'h00, R_PUSH, 16'h77, 0);
      chk("rovf.rp", bus.rp, G ? RDEPTH - 1 : 0);
      chk("rovf.rtop", bus.r_top, G ? RDEPTH - 1 : 32'h77);
      chk("rovf.ovf", bus.ovf, G ? 1 : 0);
      step(1, D_NOP, 16'h00, R_POP, 0, 0);
      chk("rovf_pop.rtop", bus.r_top, G ? RDEPTH - 2 : RDEPTH - 1);
      chk("rovf_pop.rp", bus.rp, G ? RDEPTH - 2 : RDEPTH - 1);

      // Asynchronous reset in the middle of a PUSH/DROP burst
      clear_stacks();
      step(1, D_PUSH, 16'h01, R_PUSH, 16'h3C, 0);
      step(1, D_DROP, 16'h00, R_NONE, 0, 0);
      step(1, D_PUSH, 16'h02, R_NONE, 0, 0);
      step(1, D_PUSH, 16'h04, R_NONE, 0, 0);
      @(negedge clk);
      bus.d_op = D_DROP;
      #2 rst = 1'b1;
      #1;
      chk("arst.tos", bus.tos, 0);   chk("arst.nos", bus.nos, 0);
      chk("arst.sp", bus.sp, 0);     chk("arst.rtop", bus.r_top, 0);
      chk("arst.rp", bus.rp, 0);     chk("arst.ovf", bus.ovf, 0);
      chk("arst.unf", bus.unf, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.d_op = D_NOP;
      step(1, D_PUSH, 16'h55, R_NONE, 0, 0);
      chk("post.tos", bus.tos, 32'h55);
      chk("post.nos", bus.nos, 0);
      chk("post.sp", bus.sp, 1);
      chk("post.rp", bus.rp, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
